// File: rtl/serial_addsub_pkg.sv
// ----------------------------------------------------------------------------
// serial_addsub_pkg
//   Shared types for the digit-serial add/subtract engine.
//   state_t : controller states (IDLE, RUN, DONE)
//   op_t    : operation select (OP_ADD / OP_SUB)
//   cnt_width() : digit-counter width, never below 1 bit so NDIG==1 still
//                 yields a legal vector.
// ----------------------------------------------------------------------------
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_engine_digit_adder.sv
// ----------------------------------------------------------------------------
// serial_digit_adder
//   Combinational DIGIT_W-bit adder slice with carry in/out. For subtraction
//   the B digit is inverted; the caller supplies the +1 through the first
//   carry-in, giving A + ~B + 1.
// Ports
//   a_i    [DIGIT_W-1:0]  A digit
//   b_i    [DIGIT_W-1:0]  B digit
//   op_i   op_t           OP_ADD / OP_SUB
//   cin_i                 carry in
//   s_o    [DIGIT_W-1:0]  digit sum
//   cout_o                carry out
// ----------------------------------------------------------------------------
module serial_digit_adder
    import serial_addsub_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  op_t                op_i,
    input  logic               cin_i,
    output logic [DIGIT_W-1:0] s_o,
    output logic               cout_o
);

    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   total;

    assign b_eff = (op_i == OP_SUB) ? ~b_i : b_i;
    assign total = {1'b0, a_i} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin_i};
    assign {cout_o, s_o} = total;

endmodule

// File: rtl/serial_addsub_engine.sv
// ----------------------------------------------------------------------------
// serial_addsub_engine
//   Digit-serial add/subtract engine. Operands are consumed DIGIT_W bits per
//   cycle, LSB digit first, over NDIG = NO_BIT/DIGIT_W RUN cycles. The result
//   register is written only on the last RUN cycle, so partial digits never
//   appear on o_sum, and it holds until the next operation completes.
//
//   Optional feature macro: SERIAL_ADDSUB_PARITY_EN adds o_parity = ^o_sum,
//   registered together with the result.
//
// State table
//   state | meaning
//   IDLE  | waiting for i_start
//   RUN   | one digit processed per cycle, o_busy high
//   DONE  | o_done pulse; i_start here re-enters RUN directly
//
// Ports
//   i_clk     clock, posedge
//   i_rstn    asynchronous active-low reset
//   i_start   start request, sampled when not busy
//   i_op      0 = add, 1 = subtract (sampled with i_start)
//   i_dinA    operand A (sampled with i_start)
//   i_dinB    operand B (sampled with i_start)
//   o_busy    high during RUN
//   o_done    one-cycle pulse, o_sum newly valid
//   o_sum     {carry/borrow, NO_BIT result bits}
//   o_parity  XOR of o_sum (SERIAL_ADDSUB_PARITY_EN only)
// ----------------------------------------------------------------------------
module serial_addsub_engine
    import serial_addsub_pkg::*;
#(
    parameter int NO_BIT  = 4,
    parameter int DIGIT_W = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic              i_op,
    input  logic [NO_BIT-1:0] i_dinA,
    input  logic [NO_BIT-1:0] i_dinB,
    output logic              o_busy,
    output logic              o_done,
`ifdef SERIAL_ADDSUB_PARITY_EN
    output logic [NO_BIT:0]   o_sum,
    output logic              o_parity
`else
    output logic [NO_BIT:0]   o_sum
`endif
);

    localparam int NDIG  = NO_BIT / DIGIT_W;
    localparam int CNT_W = cnt_width(NDIG);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    generate
        if ((DIGIT_W < 1) || (DIGIT_W > NO_BIT) || ((NO_BIT % DIGIT_W) != 0)) begin : g_bad_param
            $error("serial_addsub_engine: NO_BIT must be a positive multiple of DIGIT_W");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NO_BIT-1:0]   a_q, a_d;
    logic [NO_BIT-1:0]   b_q, b_d;
    op_t                 op_q, op_d;
    logic                carry_q, carry_d;
    logic [NO_BIT-1:0]   acc_q, acc_d;
    logic [NO_BIT:0]     sum_q, sum_d;

    logic [DIGIT_W-1:0]  dig_s;
    logic                dig_cout;
    logic [NO_BIT-1:0]   acc_shift;
    logic                final_msb;

    // Operand registers shift right, so the active digit is always at the bottom.
    serial_digit_adder #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a_i    (a_q[DIGIT_W-1:0]),
        .b_i    (b_q[DIGIT_W-1:0]),
        .op_i   (op_q),
        .cin_i  (carry_q),
        .s_o    (dig_s),
        .cout_o (dig_cout)
    );

    // New digits enter at the top; after NDIG shifts the first digit is at bit 0.
    assign acc_shift = NO_BIT'({dig_s, acc_q} >> DIGIT_W);

    // With A + ~B + 1, a final carry of 1 means no borrow.
    assign final_msb = (op_q == OP_SUB) ? ~dig_cout : dig_cout;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                o_busy  = 1'b1;
                a_d     = a_q >> DIGIT_W;
                b_d     = b_q >> DIGIT_W;
                carry_d = dig_cout;
                acc_d   = acc_shift;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    sum_d   = {final_msb, acc_shift};
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = i_start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operand capture happens on any accepted start, from IDLE or DONE.
        if ((state_q != RUN) && i_start) begin
            a_d     = i_dinA;
            b_d     = i_dinB;
            op_d    = op_t'(i_op);
            carry_d = i_op;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

    assign o_sum = sum_q;

`ifdef SERIAL_ADDSUB_PARITY_EN
    logic parity_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^sum_d;
        end
    end

    assign o_parity = parity_q;
`endif

endmodule
